// File: rtl/riscv_core_wb_pkg.sv
// Shared definitions for the write-back stage.
//   RFWT_*        : write-back source select encodings
//   WB_XLEN       : default data path width
//   WB_RF_ADDR_W  : default register index width
//   wb_byp_t      : bypass record {valid, rd, data}
package riscv_core_wb_pkg;

   localparam int WB_XLEN      = 32;
   localparam int WB_RF_ADDR_W = 5;

   localparam logic [1:0] RFWT_ALU  = 2'd0;
   localparam logic [1:0] RFWT_MEM  = 2'd1;
   localparam logic [1:0] RFWT_PC   = 2'd2;
   localparam logic [1:0] RFWT_RSVD = 2'd3;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_byp_t;

endpackage

// File: rtl/riscv_core_wb_instret.sv
// 64-bit retired-instruction counter (minstret).
//   clk_i, rst_i     : clock, synchronous active-high reset
//   retire_i         : one instruction retires this cycle
//   csr_we_lo_i/hi_i : CSR write of the low/high half
//   csr_wdata_i      : CSR write data
//   instret_o        : current count
module riscv_core_wb_instret (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        retire_i,
   input  logic        csr_we_lo_i,
   input  logic        csr_we_hi_i,
   input  logic [31:0] csr_wdata_i,
   output logic [63:0] instret_o
);

   logic [63:0] cnt_q;
   logic [63:0] cnt_d;

   // A CSR write takes priority over counting: the unwritten half keeps its
   // old value and the retirement of that cycle is not counted.
   always_comb begin
      cnt_d = cnt_q;
      if (csr_we_lo_i || csr_we_hi_i) begin
         if (csr_we_lo_i) cnt_d[31:0]  = csr_wdata_i;
         if (csr_we_hi_i) cnt_d[63:32] = csr_wdata_i;
      end else if (retire_i) begin
         cnt_d = cnt_q + 64'd1;  // natural 64-bit wrap
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign instret_o = cnt_q;

endmodule

// File: rtl/riscv_core_wb_stage.sv
// Write-back stage: WB pipeline registers, write-back mux, register-file
// write port, WB / WB+1 bypass data and the minstret counter.
//   CLK, RST             : clock, synchronous active-high reset
//   r_wb_*_D / r_wb_*_WE : per-register load data / enable from ME
//   wb_flush             : kill the instruction currently in WB
//   rf_*                 : register-file write port
//   fwd_wb_*             : bypass of the write happening this cycle
//   fwd_hold_*           : bypass of the write from the previous cycle
//   csr_instret_*        : CSR write port for minstret
//   instret, retire      : retired count, retirement strobe
module riscv_core_wb_stage
   import riscv_core_wb_pkg::*;
#(
   parameter int XLEN      = WB_XLEN,
   parameter int RF_ADDR_W = WB_RF_ADDR_W,
   parameter int PC_INC    = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [XLEN-1:0]      r_wb_alu_D,
   input  logic                 r_wb_alu_WE,
   input  logic [XLEN-1:0]      r_wb_memdat_D,
   input  logic                 r_wb_memdat_WE,
   input  logic [XLEN-1:0]      r_wb_pc_D,
   input  logic                 r_wb_pc_WE,
   input  logic [RF_ADDR_W-1:0] r_wb_rd_D,
   input  logic                 r_wb_rd_WE,
   input  logic                 r_wb_regwrite_D,
   input  logic                 r_wb_regwrite_WE,
   input  logic [1:0]           r_wb_rfwt_sel_D,
   input  logic                 r_wb_rfwt_sel_WE,
   input  logic                 r_wb_valid_D,
   input  logic                 r_wb_valid_WE,
   input  logic                 wb_flush,
   output logic                 rf_we,
   output logic [RF_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic                 fwd_wb_valid,
   output logic [RF_ADDR_W-1:0] fwd_wb_rd,
   output logic [XLEN-1:0]      fwd_wb_data,
   output logic                 fwd_hold_valid,
   output logic [RF_ADDR_W-1:0] fwd_hold_rd,
   output logic [XLEN-1:0]      fwd_hold_data,
   input  logic                 csr_instret_we_lo,
   input  logic                 csr_instret_we_hi,
   input  logic [31:0]          csr_instret_wdata,
   output logic [63:0]          instret,
   output logic                 retire
);

   logic [XLEN-1:0]      alu_q, memdat_q, pc_q;
   logic [RF_ADDR_W-1:0] rd_q;
   logic                 regwrite_q, valid_q;
   logic [1:0]           rfwt_sel_q;
   wb_byp_t              hold_q, hold_d;
   logic [XLEN-1:0]      wb_val;
   logic                 commit;
   logic                 we;
   logic [63:0]          cnt;

   // WB pipeline registers: independent load enables
   always_ff @(posedge CLK) begin
      if (RST) begin
         alu_q      <= '0;
         memdat_q   <= '0;
         pc_q       <= '0;
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         rfwt_sel_q <= RFWT_ALU;
         valid_q    <= 1'b0;
      end else begin
         if (r_wb_alu_WE)      alu_q      <= r_wb_alu_D;
         if (r_wb_memdat_WE)   memdat_q   <= r_wb_memdat_D;
         if (r_wb_pc_WE)       pc_q       <= r_wb_pc_D;
         if (r_wb_rd_WE)       rd_q       <= r_wb_rd_D;
         if (r_wb_regwrite_WE) regwrite_q <= r_wb_regwrite_D;
         if (r_wb_rfwt_sel_WE) rfwt_sel_q <= r_wb_rfwt_sel_D;
         if (r_wb_valid_WE)    valid_q    <= r_wb_valid_D;
      end
   end

   always_comb begin
      wb_val = alu_q;  // RFWT_ALU and the reserved encoding
      case (rfwt_sel_q)
         RFWT_MEM: wb_val = memdat_q;
         RFWT_PC:  wb_val = pc_q + XLEN'(PC_INC);
         default:  wb_val = alu_q;
      endcase
   end

   // RST gates everything combinationally so outputs read 0 while it is held,
   // not only after the edge that clears the registers.
   assign commit = valid_q & ~wb_flush & ~RST;
   assign we     = commit & regwrite_q & (rd_q != '0);

   assign rf_we        = we;
   assign rf_waddr     = RST ? '0 : rd_q;
   assign rf_wdata     = RST ? '0 : wb_val;
   assign fwd_wb_valid = we;
   assign fwd_wb_rd    = rf_waddr;
   assign fwd_wb_data  = rf_wdata;
   assign retire       = commit;

   // Hold register keeps the last real write so a consumer that read the RF
   // in the write cycle still sees it; the index/data only move on a write.
   always_comb begin
      hold_d       = hold_q;
      hold_d.valid = we;
      if (we) begin
         hold_d.rd   = rf_waddr;
         hold_d.data = rf_wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) hold_q <= '0;
      else     hold_q <= hold_d;
   end

   assign fwd_hold_valid = RST ? 1'b0 : hold_q.valid;
   assign fwd_hold_rd    = RST ? '0   : hold_q.rd;
   assign fwd_hold_data  = RST ? '0   : hold_q.data;

   riscv_core_wb_instret u_instret (
      .clk_i       (CLK),
      .rst_i       (RST),
      .retire_i    (commit),
      .csr_we_lo_i (csr_instret_we_lo),
      .csr_we_hi_i (csr_instret_we_hi),
      .csr_wdata_i (csr_instret_wdata),
      .instret_o   (cnt)
   );

   assign instret = RST ? 64'd0 : cnt;

endmodule

// File: tb/tb_riscv_core_wb_stage.sv
module tb_riscv_core_wb_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] r_wb_alu_D, r_wb_memdat_D, r_wb_pc_D;
   logic        r_wb_alu_WE, r_wb_memdat_WE, r_wb_pc_WE;
   logic [4:0]  r_wb_rd_D;
   logic        r_wb_rd_WE;
   logic        r_wb_regwrite_D, r_wb_regwrite_WE;
   logic [1:0]  r_wb_rfwt_sel_D;
   logic        r_wb_rfwt_sel_WE;
   logic        r_wb_valid_D, r_wb_valid_WE;
   logic        wb_flush;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        fwd_wb_valid;
   logic [4:0]  fwd_wb_rd;
   logic [31:0] fwd_wb_data;
   logic        fwd_hold_valid;
   logic [4:0]  fwd_hold_rd;
   logic [31:0] fwd_hold_data;
   logic        csr_instret_we_lo, csr_instret_we_hi;
   logic [31:0] csr_instret_wdata;
   logic [63:0] instret;
   logic        retire;

   riscv_core_wb_stage dut (
      .CLK(CLK), .RST(RST),
      .r_wb_alu_D(r_wb_alu_D), .r_wb_alu_WE(r_wb_alu_WE),
      .r_wb_memdat_D(r_wb_memdat_D), .r_wb_memdat_WE(r_wb_memdat_WE),
      .r_wb_pc_D(r_wb_pc_D), .r_wb_pc_WE(r_wb_pc_WE),
      .r_wb_rd_D(r_wb_rd_D), .r_wb_rd_WE(r_wb_rd_WE),
      .r_wb_regwrite_D(r_wb_regwrite_D), .r_wb_regwrite_WE(r_wb_regwrite_WE),
      .r_wb_rfwt_sel_D(r_wb_rfwt_sel_D), .r_wb_rfwt_sel_WE(r_wb_rfwt_sel_WE),
      .r_wb_valid_D(r_wb_valid_D), .r_wb_valid_WE(r_wb_valid_WE),
      .wb_flush(wb_flush),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .fwd_hold_valid(fwd_hold_valid), .fwd_hold_rd(fwd_hold_rd),
      .fwd_hold_data(fwd_hold_data),
      .csr_instret_we_lo(csr_instret_we_lo), .csr_instret_we_hi(csr_instret_we_hi),
      .csr_instret_wdata(csr_instret_wdata),
      .instret(instret), .retire(retire)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: architectural state of the WB stage
   logic [31:0] m_alu, m_mem, m_pc, m_hdata;
   logic [4:0]  m_rd, m_hrd;
   logic        m_rw, m_vld, m_hv;
   logic [1:0]  m_sel;
   logic [63:0] m_cnt;

   function automatic logic [31:0] ref_wbval();
      if (m_sel == 2'd1) return m_mem;
      if (m_sel == 2'd2) return m_pc + 32'd4;
      return m_alu;
   endfunction

   // Check outputs mid-cycle, then advance model and DUT by one edge.
   task automatic tick();
      logic        e_ret, e_we;
      logic [31:0] e_data;
      @(negedge CLK);
      e_ret  = m_vld && !wb_flush && !RST;
      e_we   = e_ret && m_rw && (m_rd != 5'd0);
      e_data = RST ? 32'd0 : ref_wbval();
      chk("rf_we",        rf_we,          e_we);
      chk("rf_waddr",     rf_waddr,       RST ? 5'd0 : m_rd);
      chk("rf_wdata",     rf_wdata,       e_data);
      chk("fwd_wb_valid", fwd_wb_valid,   e_we);
      chk("fwd_wb_rd",    fwd_wb_rd,      RST ? 5'd0 : m_rd);
      chk("fwd_wb_data",  fwd_wb_data,    e_data);
      chk("hold_valid",   fwd_hold_valid, RST ? 1'b0 : m_hv);
      chk("hold_rd",      fwd_hold_rd,    RST ? 5'd0 : m_hrd);
      chk("hold_data",    fwd_hold_data,  RST ? 32'd0 : m_hdata);
      chk("retire",       retire,         e_ret);
      chk("instret",      instret,        RST ? 64'd0 : m_cnt);
      @(posedge CLK);
      if (RST) begin
         m_alu = '0; m_mem = '0; m_pc = '0; m_rd = '0; m_rw = 0; m_sel = '0; m_vld = 0;
         m_hv = 0; m_hrd = '0; m_hdata = '0; m_cnt = '0;
      end else begin
         m_hv = e_we;
         if (e_we) begin m_hrd = m_rd; m_hdata = e_data; end
         if (csr_instret_we_lo || csr_instret_we_hi) begin
            if (csr_instret_we_lo) m_cnt = {m_cnt[63:32], csr_instret_wdata};
            if (csr_instret_we_hi) m_cnt = {csr_instret_wdata, m_cnt[31:0]};
         end else if (e_ret) begin
            m_cnt = m_cnt + 64'd1;
         end
         if (r_wb_alu_WE)      m_alu = r_wb_alu_D;
         if (r_wb_memdat_WE)   m_mem = r_wb_memdat_D;
         if (r_wb_pc_WE)       m_pc  = r_wb_pc_D;
         if (r_wb_rd_WE)       m_rd  = r_wb_rd_D;
         if (r_wb_regwrite_WE) m_rw  = r_wb_regwrite_D;
         if (r_wb_rfwt_sel_WE) m_sel = r_wb_rfwt_sel_D;
         if (r_wb_valid_WE)    m_vld = r_wb_valid_D;
      end
      #1;
   endtask

   task automatic clear_we();
      r_wb_alu_WE = 0; r_wb_memdat_WE = 0; r_wb_pc_WE = 0; r_wb_rd_WE = 0;
      r_wb_regwrite_WE = 0; r_wb_rfwt_sel_WE = 0; r_wb_valid_WE = 0;
      csr_instret_we_lo = 0; csr_instret_we_hi = 0; wb_flush = 0;
   endtask

   task automatic set_instr(input logic [31:0] alu, input logic [31:0] mem,
                            input logic [31:0] pc, input logic [4:0] rd,
                            input logic rw, input logic [1:0] sel, input logic vld);
      clear_we();
      r_wb_alu_D = alu; r_wb_memdat_D = mem; r_wb_pc_D = pc; r_wb_rd_D = rd;
      r_wb_regwrite_D = rw; r_wb_rfwt_sel_D = sel; r_wb_valid_D = vld;
      r_wb_alu_WE = 1; r_wb_memdat_WE = 1; r_wb_pc_WE = 1; r_wb_rd_WE = 1;
      r_wb_regwrite_WE = 1; r_wb_rfwt_sel_WE = 1; r_wb_valid_WE = 1;
   endtask

   task automatic bubble();
      clear_we();
      r_wb_valid_D = 0; r_wb_valid_WE = 1;
   endtask

   initial begin
      m_alu = '0; m_mem = '0; m_pc = '0; m_rd = '0; m_rw = 0; m_sel = '0; m_vld = 0;
      m_hv = 0; m_hrd = '0; m_hdata = '0; m_cnt = '0;
      RST = 1;
      set_instr(32'h0, 32'h0, 32'h0, 5'd0, 0, 2'd0, 0);
      clear_we();
      csr_instret_wdata = '0;
      #1;
      tick(); tick();
      RST = 0;

      // 1: plain ALU write-back with one-cycle latency, then hold/instret
      set_instr(32'h12345678, 32'h0, 32'h100, 5'd5, 1, 2'd0, 1);
      tick();
      chk("t1_rf_we", rf_we, 1'b1);
      chk("t1_waddr", rf_waddr, 5'd5);
      chk("t1_wdata", rf_wdata, 32'h12345678);
      chk("t1_retire", retire, 1'b1);
      bubble();
      tick();
      chk("t1_hold_valid", fwd_hold_valid, 1'b1);
      chk("t1_hold_data", fwd_hold_data, 32'h12345678);
      chk("t1_instret", instret, 64'd1);

      // 2: link value wraps, then load data select
      set_instr(32'h55555555, 32'h0, 32'hFFFFFFFC, 5'd1, 1, 2'd2, 1);
      tick();
      chk("t2_pc_wrap", rf_wdata, 32'h0);
      clear_we();
      r_wb_memdat_D = 32'hDEADBEEF; r_wb_memdat_WE = 1;
      r_wb_rfwt_sel_D = 2'd1;       r_wb_rfwt_sel_WE = 1;
      tick();
      chk("t2_memdat", rf_wdata, 32'hDEADBEEF);

      // 3: write to x0 is suppressed but retires
      set_instr(32'hAAAA0000, 32'h0, 32'h0, 5'd0, 1, 2'd0, 1);
      tick();
      chk("t3_x0_we", rf_we, 1'b0);
      chk("t3_x0_fwd", fwd_wb_valid, 1'b0);
      chk("t3_x0_retire", retire, 1'b1);
      bubble();
      tick();

      // 4: flushed instruction, then back-to-back retirements
      set_instr(32'h33, 32'h0, 32'h0, 5'd3, 1, 2'd0, 1);
      tick();
      bubble();
      wb_flush = 1;
      tick();
      for (int i = 0; i < 4; i++) begin
         set_instr($urandom, $urandom, $urandom, 5'($urandom_range(1, 31)), 1, 2'd0, 1);
         tick();
      end
      bubble();
      tick();

      // 5: instret wrap and CSR-over-retire priority
      bubble();
      csr_instret_we_lo = 1; csr_instret_we_hi = 1; csr_instret_wdata = 32'hFFFFFFFF;
      tick();
      chk("t5_preset", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      set_instr(32'h1, 32'h0, 32'h0, 5'd2, 1, 2'd0, 1);
      tick();
      bubble();
      tick();
      chk("t5_wrap", instret, 64'd0);
      set_instr(32'h2, 32'h0, 32'h0, 5'd2, 1, 2'd0, 1);
      tick();
      bubble();
      csr_instret_we_lo = 1; csr_instret_wdata = 32'h10;
      tick();
      chk("t5_csr_wins", instret, 64'h10);

      // 6: registers hold with WE low, then reset mid-stream
      set_instr(32'hCAFE0001, 32'h0, 32'h0, 5'd7, 1, 2'd0, 1);
      tick();
      clear_we();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_repeat_we", rf_we, 1'b1);
      end
      RST = 1;
      tick();
      chk("t6_rst_instret", instret, 64'd0);
      chk("t6_rst_we", rf_we, 1'b0);
      RST = 0;
      clear_we();
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         clear_we();
         r_wb_alu_D       = $urandom;
         r_wb_memdat_D    = $urandom;
         r_wb_pc_D        = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom;
         r_wb_rd_D        = 5'($urandom_range(0, 31));
         r_wb_regwrite_D  = 1'($urandom_range(0, 3) != 0);
         r_wb_rfwt_sel_D  = 2'($urandom_range(0, 3));
         r_wb_valid_D     = 1'($urandom_range(0, 3) != 0);
         r_wb_alu_WE      = 1'($urandom_range(0, 1));
         r_wb_memdat_WE   = 1'($urandom_range(0, 1));
         r_wb_pc_WE       = 1'($urandom_range(0, 1));
         r_wb_rd_WE       = 1'($urandom_range(0, 1));
         r_wb_regwrite_WE = 1'($urandom_range(0, 1));
         r_wb_rfwt_sel_WE = 1'($urandom_range(0, 1));
         r_wb_valid_WE    = 1'($urandom_range(0, 1));
         wb_flush         = 1'($urandom_range(0, 4) == 0);
         csr_instret_we_lo = 1'($urandom_range(0, 19) == 0);
         csr_instret_we_hi = 1'($urandom_range(0, 19) == 0);
         csr_instret_wdata = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
         RST = 1'($urandom_range(0, 49) == 0);
         tick();
      end
      RST = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_core_wb_stage.md
Name: riscv_core_wb_stage

Overview:
Write-back end of the ME->WB pipeline interface. Owns the WB pipeline registers (alu, memdat, pc, rd, regwrite, rfwt_sel, valid) that the ME output unit drives via D/WE pairs.
Selects the write-back value and drives the register-file write port. Provides WB and WB+1 bypass data to the decode/execute forwarding logic. Maintains the 64-bit retired-instruction counter (minstret) with a CSR write port.

Parameters:
XLEN, 32, data path width
RF_ADDR_W, 5, register index width
PC_INC, 4, added to pc for link write-back

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
r_wb_alu_D  in  32  ALU result from ME
r_wb_alu_WE  in  1  load enable, alu register
r_wb_memdat_D  in  32  load data from ME
r_wb_memdat_WE  in  1  load enable, memdat register
r_wb_pc_D  in  32  instruction PC
r_wb_pc_WE  in  1  load enable, pc register
r_wb_rd_D  in  5  destination register index
r_wb_rd_WE  in  1  load enable, rd register
r_wb_regwrite_D  in  1  instruction writes the RF
r_wb_regwrite_WE  in  1  load enable, regwrite register
r_wb_rfwt_sel_D  in  2  write-back source select
r_wb_rfwt_sel_WE  in  1  load enable, rfwt_sel register
r_wb_valid_D  in  1  instruction in ME is valid (not a bubble)
r_wb_valid_WE  in  1  load enable, valid register
wb_flush  in  1  kill the instruction currently in WB
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write index
rf_wdata  out  32  register-file write data
fwd_wb_valid  out  1  WB bypass entry valid
fwd_wb_rd  out  5  WB bypass index
fwd_wb_data  out  32  WB bypass data (equals rf_wdata)
fwd_hold_valid  out  1  previous-cycle write bypass valid
fwd_hold_rd  out  5  previous-cycle write index
fwd_hold_data  out  32  previous-cycle write data
csr_instret_we_lo  in  1  CSR write, minstret[31:0]
csr_instret_we_hi  in  1  CSR write, minstret[63:32]
csr_instret_wdata  in  32  CSR write data
instret  out  64  retired-instruction count
retire  out  1  one instruction retired this cycle

Behaviour:
- Reset (RST=1 at a CLK edge) clears every WB register, the hold register and instret to 0. While reset is asserted, all outputs are 0.
- WB registers:
  - Each register loads its D input on a CLK edge when its WE=1. Otherwise it holds.
  - WE lines are independent. Only a register whose WE is set updates.
- Write-back mux, combinational from the WB register Q values:
  - rfwt_sel 0 -> alu
  - rfwt_sel 1 -> memdat
  - rfwt_sel 2 -> pc + PC_INC, modulo 2^32 (wraps at 0xFFFFFFFC -> 0x00000000)
  - rfwt_sel 3 -> alu (reserved)
- Commit condition: commit = valid & ~wb_flush.
- RF write port:
  - rf_we = commit & regwrite & (rd != 0)
  - rf_waddr = rd
  - rf_wdata = mux output
- Latency: an instruction whose WE pulses in cycle n drives the RF port in cycle n+1.
- Writes to x0 are suppressed: rf_we=0 and fwd_wb_valid=0. That instruction still retires.
- WB bypass: fwd_wb_valid = rf_we, fwd_wb_rd = rd, fwd_wb_data = rf_wdata. All combinational.
- Hold register:
  - On each CLK edge it captures {rf_we, rf_waddr, rf_wdata}.
  - It covers a consumer that read the RF in the same cycle as the write.
  - When rf_we=0 at the edge, fwd_hold_valid becomes 0 and rd/data hold their old values.
- Retire:
  - retire = commit (combinational).
  - instret increments by 1 on each CLK edge where retire=1, with 64-bit wrap (0xFFFF_FFFF_FFFF_FFFF -> 0).
- CSR write:
  - csr_instret_we_lo/hi replace the selected half with csr_instret_wdata on the edge.
  - If retire=1 in the same cycle, the CSR write wins and no increment is applied to that cycle.
  - If both lo and hi are asserted, both halves are loaded.
- Flush:
  - wb_flush only masks the commit of the current WB contents. Registers still load on WE in the same cycle.
  - Flush and retire in the same cycle: flush wins, so no RF write and no count.
- RST asserted mid-operation overrides WE, CSR writes and counting. An instruction sitting in WB is discarded.

Decomposition:
- Shared package riscv_core_wb_pkg:
  - RFWT_ALU=2'd0, RFWT_MEM=2'd1, RFWT_PC=2'd2, RFWT_RSVD=2'd3
  - XLEN and RF_ADDR_W defaults
  - bypass record typedef {valid, rd[4:0], data[31:0]}
- One sub-module: riscv_core_wb_instret, containing the 64-bit counter, CSR write-port priority and the wrap rule. The WB registers, mux and hold register stay in the top module.

Test Plan:
1. Reset, then load alu=0x12345678, rd=5, regwrite=1, rfwt_sel=0, valid=1 (all WE=1) -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, retire=1; the cycle after: fwd_hold_valid=1, fwd_hold_data=0x12345678, instret=1.
2. rfwt_sel=2 with pc=0xFFFFFFFC, rd=1 -> rf_wdata=0x00000000. Then rfwt_sel=1 with memdat=0xDEADBEEF -> rf_wdata=0xDEADBEEF.
3. rd=0, regwrite=1, valid=1 -> rf_we=0, fwd_wb_valid=0, retire=1, instret increments.
4. valid=1 with wb_flush=1 in the WB cycle -> rf_we=0, retire=0, instret unchanged. Back-to-back unflushed instructions -> instret +1 per cycle.
5. instret preset via CSR lo=0xFFFFFFFF, hi=0xFFFFFFFF, then one retire -> instret=0. CSR lo write of 0x10 coincident with retire -> instret[31:0]=0x10 (no +1).
6. All WE=0 for 3 cycles after an instruction -> WB registers hold and rf_we repeats each cycle. Then RST asserted mid-stream -> all outputs 0 on the next edge and instret=0.
